mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter_rr_arbiter2.sv | 24 ++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter.
//   state_e      : FSM state encoding (IDLE / ISSUE / RESP)
//   M0, M1       : master index constants, also the encoding of owner
//   LOCK_MAX_DEF : default cap on consecutive locked grants
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int LOCK_MAX_DEF = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every non-clock signal around the arbiter: two master request
// ports (req/we/lock/addr/wd in, ack/rd out), the shared memory port
// (mem_we/mem_addr/mem_wd out, mem_rd in) and the status outputs owner/busy.
//   modport slave  : arbiter view
//   modport master : view of the surrounding masters + memory
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              m0_req, m0_we, m0_lock, m0_ack;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wd, m0_rd;

  logic              m1_req, m1_we, m1_lock, m1_ack;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wd, m1_rd;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd, mem_rd;

  logic              owner, busy;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wd,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wd,
    input  mem_rd,
    output m0_ack, m0_rd, m1_ack, m1_rd,
    output mem_we, mem_addr, mem_wd,
    output owner, busy
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wd,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wd,
    output mem_rd,
    input  m0_ack, m0_rd, m1_ack, m1_rd,
    input  mem_we, mem_addr, mem_wd,
    input  owner, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Combinational 2-way round-robin grant.
//   req_i       : request bits, index = master
//   last_i      : master granted most recently
//   gnt_valid_o : at least one request present
//   gnt_idx_o   : winning master (a lone requester wins; a tie goes to !last_i)
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    case (req_i)
      2'b10:   gnt_idx_o = M1;
      2'b11:   gnt_idx_o = ~last_i;
      default: gnt_idx_o = M0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto a single synchronous memory port.
// Each transaction is ISSUE (address/data/write strobe presented) followed by
// RESP (memory read data returned, owner acked), so back-to-back traffic runs
// at one access per two cycles with no idle cycle between owners.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_arbiter_if.slave (master ports, memory port, owner, busy)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [1:0]        req, lock_eff, we;
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wd   [2];

  assign req      = {bus.m1_req, bus.m0_req};
  // A lock bit only counts while its master is actually requesting.
  assign lock_eff = {bus.m1_lock, bus.m0_lock} & req;
  assign we       = {bus.m1_we, bus.m0_we};
  assign addr[0]  = bus.m0_addr;
  assign addr[1]  = bus.m1_addr;
  assign wd[0]    = bus.m0_wd;
  assign wd[1]    = bus.m1_wd;

  state_e            state_q;
  logic              owner_q, rr_last_q, busy_q, mem_we_q;
  logic [1:0]        ack_q;
  logic [CNT_W-1:0]  lock_cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wd_q;

  logic              gnt_valid, gnt_idx;
  logic              owner_d, relock_d;
  logic [CNT_W-1:0]  lock_cnt_d;

  rr_arbiter2 u_rr (
    .req_i       (req),
    .last_i      (rr_last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Locked re-grant bypasses round-robin until the owner has been re-granted
  // LOCK_MAX times; after that one normal arbitration is forced.
  always_comb begin
    relock_d = 1'b0;
    owner_d  = gnt_idx;
    if (state_q == ST_RESP && lock_eff[owner_q] && lock_cnt_q < CNT_W'(LOCK_MAX)) begin
      relock_d = 1'b1;
      owner_d  = owner_q;
    end
    lock_cnt_d = relock_d ? lock_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= M0;
      rr_last_q  <= M1;   // so m0 takes the first tie
      busy_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      ack_q      <= 2'b00;
      lock_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          state_q  <= ST_RESP;
          mem_we_q <= 1'b0;   // address held, write strobe only one cycle
          ack_q    <= (owner_q == M1) ? 2'b10 : 2'b01;
        end
        default: begin      // ST_IDLE, ST_RESP (and any illegal code)
          ack_q <= 2'b00;
          if (relock_d || gnt_valid) begin
            state_q    <= ST_ISSUE;
            owner_q    <= owner_d;
            rr_last_q  <= owner_d;
            busy_q     <= 1'b1;
            mem_we_q   <= we[owner_d];
            mem_addr_q <= addr[owner_d];
            mem_wd_q   <= wd[owner_d];
            lock_cnt_q <= lock_cnt_d;
          end else begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            lock_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  assign bus.m0_ack   = ack_q[0];
  assign bus.m1_ack   = ack_q[1];
  // Read data is the memory's registered output, passed through only while acked.
  assign bus.m0_rd    = ack_q[0] ? bus.mem_rd : '0;
  assign bus.m1_rd    = ack_q[1] ? bus.mem_rd : '0;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd   = mem_wd_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          m;
    logic        chk_rd;
    logic [31:0] rd;
    int          at;
  } exp_t;

  exp_t sb[$];

  // Synchronous memory: read data one cycle after the address.
  logic [31:0] mem [256];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10]  <= 32'hDEADBEEF;
      mem[8'h14]  <= 32'h11112222;
      bus.mem_rd  <= '0;
      mem_init    <= 1'b1;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wd;
      bus.mem_rd <= mem[bus.mem_addr[7:0]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ack(input int m, input logic chk, input logic [31:0] rd, input int at);
    exp_t e;
    e.m = m; e.chk_rd = chk; e.rd = rd; e.at = at;
    sb.push_back(e);
  endtask

  task automatic set_m(input int m, input logic req, input logic we, input logic lk,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lk; bus.m0_addr = addr; bus.m0_wd = wd;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lk; bus.m1_addr = addr; bus.m1_wd = wd;
    end
  endtask

  // Holds a request up until ntx acks have been seen, then drops it.
  task automatic drive(input int m, input int ntx, input logic we, input logic lk,
                       input logic [31:0] addr, input logic [31:0] wd);
    int got = 0;
    int budget = 0;
    set_m(m, 1'b1, we, lk, addr, wd);
    while (got < ntx && budget < 200) begin
      @(negedge clk);
      budget++;
      if ((m == 0 && bus.m0_ack) || (m == 1 && bus.m1_ack)) got++;
    end
    set_m(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("acks_received", 64'(got), 64'(ntx));
  endtask

  // Monitor: pops the scoreboard on every ack, plus bus invariants.
  int          mon_m;
  exp_t        mon_e;
  int          we_cnt  = 0;
  logic [31:0] we_addr = '0;
  logic [31:0] we_wd   = '0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m0_ack || bus.m1_ack) begin
        mon_m = bus.m1_ack ? 1 : 0;
        check("single_ack", 64'(bus.m0_ack & bus.m1_ack), 64'd0);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ack: got ack from m%0d, want none (cycle %0d)", mon_m, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("grant_master", 64'(mon_m), 64'(mon_e.m));
          check("owner", 64'(bus.owner), 64'(mon_e.m));
          if (mon_e.at >= 0) check("ack_cycle", 64'(cyc), 64'(mon_e.at));
          if (mon_e.chk_rd) check("rdata", 64'(mon_m == 1 ? bus.m1_rd : bus.m0_rd), 64'(mon_e.rd));
          check("other_rd_zero", 64'(mon_m == 1 ? bus.m0_rd : bus.m1_rd), 64'd0);
        end
      end else begin
        check("rd_zero_no_ack", 64'({bus.m1_rd, bus.m0_rd}), 64'd0);
      end
      if (!bus.busy) begin
        check("idle_mem_we", 64'(bus.mem_we), 64'd0);
        check("idle_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("idle_mem_wd", 64'(bus.mem_wd), 64'd0);
      end
      if (bus.mem_we) begin
        we_cnt++;
        we_addr = bus.mem_addr;
        we_wd   = bus.mem_wd;
        check("we_one_cycle", 64'(prev_we), 64'd0);
      end
      prev_we = bus.mem_we;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, want finish", cyc);
    $fatal(1, "timeout");
  end

  int n;
  int w0;

  initial begin
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_owner", 64'(bus.owner), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_acks", 64'({bus.m1_ack, bus.m0_ack}), 64'd0);
    check("rst_rds", 64'({bus.m1_rd, bus.m0_rd}), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Contention from reset: m0, m1, m0, m1, acks every 2 cycles
    n = cyc;
    expect_ack(0, 1'b1, 32'hDEADBEEF, n + 2);
    expect_ack(1, 1'b1, 32'h11112222, n + 4);
    expect_ack(0, 1'b1, 32'hDEADBEEF, n + 6);
    expect_ack(1, 1'b1, 32'h11112222, n + 8);
    fork
      drive(0, 2, 1'b0, 1'b0, 32'h10, 32'h0);
      drive(1, 2, 1'b0, 1'b0, 32'h14, 32'h0);
    join
    @(negedge clk);

    // Single read by m0
    @(negedge clk);
    n = cyc;
    expect_ack(0, 1'b1, 32'hDEADBEEF, n + 2);
    drive(0, 1, 1'b0, 1'b0, 32'h10, 32'h0);

    // Single write by m1: one-cycle strobe with the right address/data
    @(negedge clk);
    w0 = we_cnt;
    n  = cyc;
    expect_ack(1, 1'b0, 32'h0, n + 2);
    drive(1, 1, 1'b1, 1'b0, 32'h20, 32'h0000CAFE);
    check("write_strobes", 64'(we_cnt - w0), 64'd1);
    check("write_addr", 64'(we_addr), 64'h20);
    check("write_data", 64'(we_wd), 64'h0000CAFE);

    // Read back what m1 wrote
    @(negedge clk);
    n = cyc;
    expect_ack(0, 1'b1, 32'h0000CAFE, n + 2);
    drive(0, 1, 1'b0, 1'b0, 32'h20, 32'h0);

    // Lock cap (LOCK_MAX = 4): m1 gets 5 grants, then m0, then m1 again
    @(negedge clk);
    n = cyc;
    for (int i = 0; i < 5; i++) expect_ack(1, 1'b1, 32'h11112222, n + 2 + 2 * i);
    expect_ack(0, 1'b1, 32'hDEADBEEF, n + 12);
    expect_ack(1, 1'b1, 32'h11112222, n + 14);
    fork
      drive(1, 6, 1'b0, 1'b1, 32'h14, 32'h0);
      begin
        @(negedge clk);
        drive(0, 1, 1'b0, 1'b0, 32'h10, 32'h0);
      end
    join
    @(negedge clk);

    // Request dropped right after grant still completes
    @(negedge clk);
    n = cyc;
    expect_ack(0, 1'b1, 32'h11112222, n + 2);
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h14, 32'h0);
    repeat (3) @(negedge clk);

    // Reset during ISSUE of a write
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h00001234);
    @(posedge clk);
    #2;
    check("we_in_issue", 64'(bus.mem_we), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_we", 64'(bus.mem_we), 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_ack", 64'({bus.m1_ack, bus.m0_ack}), 64'd0);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("no_write_after_rst", 64'(mem[8'h30]), 64'd0);

    // Normal service after reset
    n = cyc;
    expect_ack(0, 1'b1, 32'hDEADBEEF, n + 2);
    drive(0, 1, 1'b0, 1'b0, 32'h10, 32'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
